// File: rtl/fwd_scoreboard_if.sv
// Bundles the decode-side inputs, per-stage result buses and forwarding outputs
// of the operand-forwarding / load-use hazard unit.
interface fwd_scoreboard_if #(
  parameter int REG_W  = 8,
  parameter int DATA_W = 32,
  parameter int NSRC   = 2,
  parameter int DEPTH  = 3
);
  logic                    adv;
  logic                    i_valid;
  logic [REG_W-1:0]        i_dstE;
  logic [REG_W-1:0]        i_dstM;
  logic [NSRC*REG_W-1:0]   i_src;
  logic [NSRC*DATA_W-1:0]  i_rval;
  logic [DEPTH*DATA_W-1:0] st_valE;
  logic [DEPTH*DATA_W-1:0] st_valM;
  logic [NSRC*DATA_W-1:0]  o_val;
  logic                    o_stall;
  logic [15:0]             o_stall_cnt;
  logic [DEPTH*REG_W-1:0]  o_tag_dstE;
  logic [DEPTH*REG_W-1:0]  o_tag_dstM;

  modport master (
    output adv, i_valid, i_dstE, i_dstM, i_src, i_rval, st_valE, st_valM,
    input  o_val, o_stall, o_stall_cnt, o_tag_dstE, o_tag_dstM
  );

  modport slave (
    input  adv, i_valid, i_dstE, i_dstM, i_src, i_rval, st_valE, st_valM,
    output o_val, o_stall, o_stall_cnt, o_tag_dstE, o_tag_dstM
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Operand forwarding and load-use hazard detection for the Y86 pipeline,
// tracking in-flight destination tags in a private shift register.
module fwd_scoreboard #(
  parameter int               REG_W   = 8,
  parameter int               DATA_W  = 32,
  parameter logic [REG_W-1:0] RNONE   = 8'h0F,
  parameter int               NSRC    = 2,
  parameter int               DEPTH   = 3,
  parameter int               MEM_RDY = 1
) (
  input logic             clk,
  input logic             rst,
  fwd_scoreboard_if.slave bus
);

  logic [REG_W-1:0]       tag_e_q [DEPTH];
  logic [REG_W-1:0]       tag_e_d [DEPTH];
  logic [REG_W-1:0]       tag_m_q [DEPTH];
  logic [REG_W-1:0]       tag_m_d [DEPTH];
  logic [15:0]            cnt_q;
  logic [15:0]            cnt_d;

  logic [NSRC*DATA_W-1:0] fwd_val;
  logic [NSRC-1:0]        haz;
  logic                   hit;
  logic [REG_W-1:0]       src;
  logic [DATA_W-1:0]      val_e;
  logic [DATA_W-1:0]      val_m;
  logic                   stall;

  // Youngest stage first; the first tag hit ends the scan. RNONE sources are
  // treated as already resolved so that bubble tags can never match them.
  always_comb begin
    fwd_val = bus.i_rval;
    haz     = '0;
    hit     = 1'b0;
    src     = '0;
    val_e   = '0;
    val_m   = '0;
    for (int n = 0; n < NSRC; n++) begin
      src = bus.i_src[n*REG_W +: REG_W];
      hit = (src == RNONE);
      for (int k = 0; k < DEPTH; k++) begin
        val_e = bus.st_valE[k*DATA_W +: DATA_W];
        val_m = bus.st_valM[k*DATA_W +: DATA_W];
        if (!hit) begin
          if (tag_m_q[k] == src) begin
            hit = 1'b1;
            if (k >= MEM_RDY) begin
              fwd_val[n*DATA_W +: DATA_W] = val_m;
            end else begin
              haz[n] = 1'b1;
            end
          end else if (tag_e_q[k] == src) begin
            hit = 1'b1;
            fwd_val[n*DATA_W +: DATA_W] = val_e;
          end
        end
      end
    end
  end

  assign stall = bus.i_valid && (|haz);

  always_comb begin
    tag_e_d = tag_e_q;
    tag_m_d = tag_m_q;
    cnt_d   = cnt_q;
    if (bus.adv) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        tag_e_d[k] = tag_e_q[k-1];
        tag_m_d[k] = tag_m_q[k-1];
      end
      // A stalled decode stays put, so a bubble enters E in its place.
      if (bus.i_valid && !stall) begin
        tag_e_d[0] = bus.i_dstE;
        tag_m_d[0] = bus.i_dstM;
      end else begin
        tag_e_d[0] = RNONE;
        tag_m_d[0] = RNONE;
      end
      if (stall && (cnt_q != 16'hFFFF)) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        tag_e_q[k] <= RNONE;
        tag_m_q[k] <= RNONE;
      end
      cnt_q <= '0;
    end else begin
      tag_e_q <= tag_e_d;
      tag_m_q <= tag_m_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_tag
    assign bus.o_tag_dstE[g*REG_W +: REG_W] = tag_e_q[g];
    assign bus.o_tag_dstM[g*REG_W +: REG_W] = tag_m_q[g];
  end

  assign bus.o_val       = fwd_val;
  assign bus.o_stall     = stall;
  assign bus.o_stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench: stimulus queues expected outputs, a monitor drains and
// compares them on the falling edge (or on demand between edges).
module tb_fwd_scoreboard;

  localparam logic [7:0] RN    = 8'h0F;
  localparam int         SAT_D = 32;

  localparam int K_VAL    = 0;
  localparam int K_STALL  = 1;
  localparam int K_CNT    = 2;
  localparam int K_TAGE   = 3;
  localparam int K_TAGM   = 4;
  localparam int K_SSTALL = 5;
  localparam int K_SCNT   = 6;

  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [63:0] exp;
  } exp_t;

  logic clk;
  logic rst;
  logic rst_sat;
  int   n_cmp;
  int   n_bad;
  exp_t q[$];
  event chk;

  fwd_scoreboard_if #(.REG_W(8), .DATA_W(32), .NSRC(2), .DEPTH(3)) b ();
  fwd_scoreboard_if #(.REG_W(8), .DATA_W(32), .NSRC(2), .DEPTH(SAT_D)) sb ();

  fwd_scoreboard #(
    .REG_W(8), .DATA_W(32), .RNONE(8'h0F), .NSRC(2), .DEPTH(3), .MEM_RDY(1)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  fwd_scoreboard #(
    .REG_W(8), .DATA_W(32), .RNONE(8'h0F), .NSRC(2), .DEPTH(SAT_D), .MEM_RDY(SAT_D)
  ) u_sat (
    .clk (clk),
    .rst (rst_sat),
    .bus (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string name, input int kind, input int idx, input logic [63:0] v);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.idx  = idx;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic v, input logic [7:0] de, input logic [7:0] dm,
                     input logic [7:0] s0, input logic [7:0] s1);
    b.i_valid = v;
    b.i_dstE  = de;
    b.i_dstM  = dm;
    b.i_src   = {s1, s0};
  endtask

  task automatic flush();
    dec(1'b0, RN, RN, RN, RN);
    repeat (3) tick();
  endtask

  // Monitor: drains every pending expectation against the current outputs.
  always begin
    @(negedge clk or chk);
    while (q.size() > 0) begin
      exp_t        e;
      logic [63:0] act;
      e = q.pop_front();
      case (e.kind)
        K_VAL:    act = 64'(b.o_val[e.idx*32 +: 32]);
        K_STALL:  act = 64'(b.o_stall);
        K_CNT:    act = 64'(b.o_stall_cnt);
        K_TAGE:   act = 64'(b.o_tag_dstE);
        K_TAGM:   act = 64'(b.o_tag_dstM);
        K_SSTALL: act = 64'(sb.o_stall);
        default:  act = 64'(sb.o_stall_cnt);
      endcase
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    int  c;
    int  ecnt;
    bit  stall_e;

    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    rst_sat = 1'b0;
    b.adv = 1'b1;
    dec(1'b0, RN, RN, RN, RN);
    b.i_rval  = '0;
    b.st_valE = '0;
    b.st_valM = '0;
    sb.adv     = 1'b1;
    sb.i_valid = 1'b1;
    sb.i_dstE  = RN;
    sb.i_dstM  = 8'h05;
    sb.i_src   = {RN, 8'h05};
    sb.i_rval  = '0;
    sb.st_valE = '0;
    sb.st_valM = '0;

    repeat (2) @(posedge clk);
    #1;
    // Reset state
    rst = 1'b1;
    dec(1'b0, RN, RN, 8'h03, RN);
    b.i_rval = {32'h0, 32'h11};
    push("rst_tagE", K_TAGE, 0, 64'h0F0F0F);
    push("rst_tagM", K_TAGM, 0, 64'h0F0F0F);
    push("rst_cnt", K_CNT, 0, 64'h0);
    push("rst_val0", K_VAL, 0, 64'h11);
    push("rst_stall", K_STALL, 0, 64'h0);
    tick();

    // Priority chain: same dstE in all three stages
    dec(1'b1, 8'h02, RN, RN, RN);
    repeat (3) tick();
    dec(1'b0, RN, RN, 8'h02, RN);
    b.i_rval  = {32'h0, 32'h77};
    b.st_valE = {32'hC, 32'hB, 32'hA};
    push("chain_tagE", K_TAGE, 0, 64'h020202);
    push("chain_val0_s0", K_VAL, 0, 64'hA);
    push("chain_stall", K_STALL, 0, 64'h0);
    tick();
    push("chain_val0_s1", K_VAL, 0, 64'hB);
    push("chain_tagE_bub", K_TAGE, 0, 64'h02020F);
    tick();
    flush();
    push("flush_tagE", K_TAGE, 0, 64'h0F0F0F);

    // Load-use
    b.st_valE = '0;
    dec(1'b1, RN, 8'h05, RN, RN);
    tick();
    dec(1'b1, 8'h06, RN, RN, 8'h05);
    b.st_valM = {32'h0, 32'hDEAD, 32'h0};
    b.i_rval  = {32'h99, 32'h0};
    push("lu_stall", K_STALL, 0, 64'h1);
    push("lu_cnt_pre", K_CNT, 0, 64'h0);
    tick();
    push("lu_stall_next", K_STALL, 0, 64'h0);
    push("lu_cnt", K_CNT, 0, 64'h1);
    push("lu_val1", K_VAL, 1, 64'hDEAD);
    push("lu_tagM", K_TAGM, 0, 64'h0F050F);
    push("lu_tagE", K_TAGE, 0, 64'h0F0F0F);
    tick();
    flush();

    // popl %esp: dstE and dstM both equal the source
    dec(1'b1, 8'h04, 8'h04, RN, RN);
    tick();
    dec(1'b1, RN, RN, 8'h04, RN);
    b.st_valE = {32'h0, 32'h100, 32'h0};
    b.st_valM = {32'h0, 32'h200, 32'h0};
    b.i_rval  = {32'h0, 32'h33};
    push("popl_stall_s0", K_STALL, 0, 64'h1);
    tick();
    push("popl_stall", K_STALL, 0, 64'h0);
    push("popl_val0", K_VAL, 0, 64'h200);
    push("popl_tagE", K_TAGE, 0, 64'h0F040F);
    push("popl_cnt", K_CNT, 0, 64'h2);
    tick();
    flush();

    // Own destination never matches; RNONE sources pass through
    dec(1'b1, 8'h07, 8'h07, 8'h07, RN);
    b.i_rval = {32'h55, 32'h44};
    push("self_val0", K_VAL, 0, 64'h44);
    push("self_stall", K_STALL, 0, 64'h0);
    tick();
    dec(1'b1, RN, RN, RN, RN);
    b.i_rval = {32'h55, 32'h66};
    push("rnone_val0", K_VAL, 0, 64'h66);
    push("rnone_val1", K_VAL, 1, 64'h55);
    push("rnone_stall", K_STALL, 0, 64'h0);
    tick();
    flush();

    // Freeze mid-stall
    dec(1'b1, RN, 8'h09, RN, RN);
    tick();
    dec(1'b1, RN, RN, 8'h09, RN);
    b.st_valM = {32'h0, 32'hBEEF, 32'h0};
    b.adv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push($sformatf("frz_stall_%0d", i), K_STALL, 0, 64'h1);
      push($sformatf("frz_cnt_%0d", i), K_CNT, 0, 64'h2);
      push($sformatf("frz_tagM_%0d", i), K_TAGM, 0, 64'h0F0F09);
      tick();
    end
    b.adv = 1'b1;
    push("frz_stall_go", K_STALL, 0, 64'h1);
    tick();
    push("frz_cnt_after", K_CNT, 0, 64'h3);
    push("frz_stall_after", K_STALL, 0, 64'h0);
    push("frz_val0", K_VAL, 0, 64'hBEEF);
    tick();
    flush();

    // Reset in the middle of a stall
    dec(1'b1, RN, 8'h09, RN, RN);
    tick();
    dec(1'b1, RN, RN, 8'h09, RN);
    push("rms_stall_pre", K_STALL, 0, 64'h1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    push("rms_stall_rst", K_STALL, 0, 64'h0);
    push("rms_cnt_rst", K_CNT, 0, 64'h0);
    push("rms_tagM_rst", K_TAGM, 0, 64'h0F0F0F);
    -> chk;
    tick();
    rst = 1'b1;
    push("rms_stall_rel", K_STALL, 0, 64'h0);
    tick();
    push("rms_stall_next", K_STALL, 0, 64'h0);
    tick();

    // Counter saturation: a stall lasts SAT_D cycles then one free cycle
    rst_sat = 1'b1;
    c = 0;
    ecnt = 0;
    while (ecnt < 65536 && c < 80000) begin
      stall_e = (c % (SAT_D + 1)) != 0;
      if (c == 0 || c == 1 || c == SAT_D + 1)
        push($sformatf("sat_stall_c%0d", c), K_SSTALL, 0, 64'(stall_e));
      if (ecnt == 1 || ecnt == 65534 || ecnt == 65535)
        push($sformatf("sat_cnt_%0d", ecnt), K_SCNT, 0, 64'(ecnt));
      tick();
      if (stall_e) ecnt++;
      c++;
    end
    n_cmp++;
    if (ecnt != 65536) begin
      n_bad++;
      $display("FAIL sat_loop_bound: got %0d stalls expected 65536", ecnt);
    end
    push("sat_hold", K_SCNT, 0, 64'hFFFF);
    @(negedge clk);
    #1;
    rst_sat = 1'b0;
    #1;
    rst_sat = 1'b1;
    push("sat_async_clr", K_SCNT, 0, 64'h0);
    -> chk;
    #1;

    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
